puf_response_collector: RTL and testbench
=========================================

# puf_response_collector

Sequencer and post-processor that drives the arbiter PUF core and turns its raw single-bit responses into a stable 8-bit response word. It generates challenges from an 8-bit LFSR, launches a race pulse per trial, synchronizes and samples the arbiter output, and majority-votes repeated trials per challenge. It sits directly around the PUF: its `challenge`/`pulse` outputs feed the PUF inputs, and the PUF response bit returns on `resp_in`.

## Interface
- `SETTLE_CYCLES`, 4: cycles with pulse low after launch before sampling; legal range ≥3, which covers the 2-flop synchronizer.
- `VOTES`, 5: trials per challenge; must be odd and ≥1.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request a run; sampled only in IDLE.
- `seed` in 8: LFSR seed, captured when `start` is accepted; 0x00 is replaced by 0x01.
- `resp_in` in 1: PUF response bit, asynchronous to `clk`.
- `challenge` out 8: challenge driven to the PUF; registered.
- `pulse` out 1: race launch to the PUF; registered.
- `busy` out 1: high from the cycle after accept through the last SAMPLE.
- `done` out 1: one-cycle pulse when `response` updates.
- `response` out 8: result word; holds its value until the next `done`.

## Operation
- States: IDLE, LAUNCH, SETTLE, SAMPLE, DONE.
- IDLE, `start`=1: capture the seed into the LFSR, clear the bit index, vote counter, trial counter and shift register, then go to LAUNCH.
- IDLE, `start`=0: stay in IDLE.
- LAUNCH: `pulse`=1 for exactly 1 cycle, then go to SETTLE.
- SETTLE: `pulse`=0 for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: add the synchronized `resp_in` into the ones counter and increment the trial counter.
  - If trials < VOTES: go to LAUNCH.
  - Otherwise: majority = (ones > VOTES/2). Shift left into the shift register (first bit ends in bit 7). Advance the LFSR, clear the counters, increment the bit index. If the bit index was 7, go to DONE; otherwise go to LAUNCH.
- DONE: `response` ← shift register, `done`=1 for one cycle, then go to IDLE.
- LFSR advance: next = {c[6:0], c[7]^c[5]^c[4]^c[3]}.
- `challenge` = LFSR state. It is constant across all VOTES trials of one bit.
- Ones counter width: $clog2(VOTES+1).
- `resp_in` passes through a 2-flop synchronizer that runs every cycle.
- `start` while busy or in DONE: ignored.
- Reset values: `challenge`=0, `pulse`=0, `busy`=0, `done`=0, `response`=0x00, state=IDLE.
- Reset mid-run: on the next edge all outputs return to their reset values and no partial result is published.

## Timing
- Trial length: SETTLE_CYCLES+2 cycles.
- Run length: 8·VOTES·(SETTLE_CYCLES+2) cycles; 240 with the default parameters.
- Accept edge = edge 0. `pulse` first rises in cycle 1. `done` is high in cycle 8·VOTES·(SETTLE_CYCLES+2)+1, which is cycle 241 with the defaults.
- `response` is valid in the same cycle as `done` and stays stable afterwards.
- `busy` falls in the `done` cycle.
- `challenge` changes only on the edge that leaves a bit's final SAMPLE, never while `pulse`=1 or during SETTLE.
- Pulses per run: exactly 8·VOTES.
- Earliest next accept: a `start` in the cycle after `done`.

## Structure
- Shared package `puf_pkg`: state enum, LFSR tap mask 8'hB8 (bits 7,5,4,3), default SETTLE_CYCLES/VOTES, response width 8.
- Sub-module `puf_lfsr8`: load, enable, seed-zero substitution, 8-bit state output.
- Synchronizer, FSM, counters and shift register stay in the top level.
- Parameter checks (odd VOTES, SETTLE_CYCLES ≥3) are elaboration-time assertions.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles -> all outputs 0 and state IDLE; `start` during reset is ignored.
- Constant model `resp_in`=1, `seed`=0x01 -> `done` at cycle 241, `response`=0xFF, 40 `pulse` highs counted.
- Model `resp_in`=`challenge[0]`, `seed`=0x01 -> challenges 01,02,04,08,11,23,47,8E in order, `response`=0x8E.
- Noisy model, `resp_in`=1 on trials 1–2 of each group and 0 on trials 3–5 -> `response`=0x00. With `resp_in`=1 on trials 1–3 -> `response`=0xFF.
- `seed`=0x00 with the `challenge[0]` model -> identical to the seed 0x01 run, `response`=0x8E.
- Robustness:
  - Pulse `start` at cycle 50 of a run -> no effect.
  - Drop `rst_n` at cycle 100 -> next cycle `busy`=0, `pulse`=0, `response`=0x00.
  - Restart with `seed`=0x01 -> full 241-cycle latency and correct result.

Source files
------------

// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
// Shared definitions for the arbiter PUF response collector: FSM state
// encoding, LFSR feedback taps, default timing/vote parameters, response width
// and the LFSR next-state helper.
// Ports: none (package).
// -----------------------------------------------------------------------------
package puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   // Feedback taps: bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS         = 8'hB8;
   localparam int         DEF_SETTLE_CYCLES = 4;
   localparam int         DEF_VOTES         = 5;
   localparam int         RESP_W            = 8;

   // Shift left, new LSB is the XOR of the tapped bits
   function automatic logic [7:0] lfsr_next(input logic [7:0] c);
      return {c[6:0], ^(c & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/puf_lfsr8.sv
// -----------------------------------------------------------------------------
// puf_lfsr8
// 8-bit Fibonacci LFSR that generates PUF challenges. A load takes priority
// over an advance; a zero seed is replaced by 0x01 so the register can never
// lock up in the all-zero state.
// Ports:
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset (state -> 0x00)
//   i_load   : capture i_seed
//   i_en     : advance one step
//   i_seed   : seed value
//   o_state  : current LFSR state
// -----------------------------------------------------------------------------
module puf_lfsr8
   import puf_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_load,
   input  logic       i_en,
   input  logic [7:0] i_seed,
   output logic [7:0] o_state
);

   logic [7:0] r_state;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= 8'h00;
      end else if (i_load) begin
         r_state <= (i_seed == 8'h00) ? 8'h01 : i_seed;
      end else if (i_en) begin
         r_state <= lfsr_next(r_state);
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/puf_response_collector.sv
// -----------------------------------------------------------------------------
// puf_response_collector
// Drives an arbiter PUF: issues LFSR challenges, launches one race pulse per
// trial, samples the synchronized arbiter bit, majority-votes VOTES trials per
// challenge and assembles eight voted bits into the response word.
// Ports:
//   i_clk       : sole clock
//   i_rst_n     : synchronous active-low reset
//   i_start     : request a run (honoured only in IDLE)
//   i_seed      : LFSR seed captured on accept (0x00 -> 0x01)
//   i_resp_in   : PUF response bit, asynchronous to i_clk
//   o_challenge : challenge to the PUF (LFSR state)
//   o_pulse     : race launch pulse to the PUF
//   o_busy      : run in progress
//   o_done      : one-cycle strobe when o_response updates
//   o_response  : last completed response word
//
// state  | meaning
// IDLE   | waiting for i_start
// LAUNCH | o_pulse high for one cycle
// SETTLE | o_pulse low, arbiter resolving, SETTLE_CYCLES cycles
// SAMPLE | accumulate one trial, vote after VOTES trials
// DONE   | o_response published, o_done high
// -----------------------------------------------------------------------------
module puf_response_collector
   import puf_pkg::*;
#(
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int VOTES         = DEF_VOTES
)
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [7:0]        i_seed,
   input  logic              i_resp_in,
   output logic [7:0]        o_challenge,
   output logic              o_pulse,
   output logic              o_busy,
   output logic              o_done,
   output logic [RESP_W-1:0] o_response
);

   localparam int CW = $clog2(VOTES + 1);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   if ((VOTES < 1) || ((VOTES % 2) != 1)) begin : g_bad_votes
      $error("puf_response_collector: VOTES must be odd and >= 1");
   end
   if (SETTLE_CYCLES < 3) begin : g_bad_settle
      $error("puf_response_collector: SETTLE_CYCLES must be >= 3");
   end

   state_t            r_state;
   logic              r_sync1;
   logic              r_sync2;
   logic [CW-1:0]     r_ones;
   logic [CW-1:0]     r_trials;
   logic [SW-1:0]     r_settle;
   logic [2:0]        r_bit_idx;
   logic [RESP_W-1:0] r_shift;
   logic [RESP_W-1:0] r_response;
   logic              r_pulse;
   logic              r_busy;
   logic              r_done;

   logic              w_lfsr_load;
   logic              w_lfsr_en;
   logic [7:0]        w_lfsr_state;
   logic [CW-1:0]     w_ones_next;
   logic [CW-1:0]     w_trials_next;
   logic              w_last_trial;
   logic              w_majority;
   logic [RESP_W-1:0] w_shift_next;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_resp_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_ones_next   = r_ones + CW'(r_sync2);
   assign w_trials_next = r_trials + CW'(1);
   assign w_last_trial  = (w_trials_next >= CW'(VOTES));
   assign w_majority    = (w_ones_next > CW'(VOTES / 2));
   assign w_shift_next  = {r_shift[RESP_W-2:0], w_majority};

   assign w_lfsr_load = (r_state == ST_IDLE) && i_start;
   // Challenge advances only on the edge leaving a bit's final SAMPLE
   assign w_lfsr_en   = (r_state == ST_SAMPLE) && w_last_trial;

   puf_lfsr8 u_lfsr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_lfsr_load),
      .i_en    (w_lfsr_en),
      .i_seed  (i_seed),
      .o_state (w_lfsr_state)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_ones     <= '0;
         r_trials   <= '0;
         r_settle   <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_response <= '0;
         r_pulse    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_ones    <= '0;
                  r_trials  <= '0;
                  r_bit_idx <= '0;
                  r_shift   <= '0;
                  r_busy    <= 1'b1;
                  r_pulse   <= 1'b1;
                  r_state   <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               // Down-counter reaches zero in the last settle cycle
               r_settle <= SW'(SETTLE_CYCLES - 1);
               r_state  <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (r_settle == '0) begin
                  r_state <= ST_SAMPLE;
               end else begin
                  r_settle <= r_settle - 1'b1;
               end
            end
            ST_SAMPLE: begin
               if (!w_last_trial) begin
                  r_ones   <= w_ones_next;
                  r_trials <= w_trials_next;
                  r_pulse  <= 1'b1;
                  r_state  <= ST_LAUNCH;
               end else begin
                  r_ones    <= '0;
                  r_trials  <= '0;
                  r_shift   <= w_shift_next;
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
                     // Publish here so o_response is valid alongside o_done
                     r_response <= w_shift_next;
                     r_done     <= 1'b1;
                     r_busy     <= 1'b0;
                     r_state    <= ST_DONE;
                  end else begin
                     r_pulse <= 1'b1;
                     r_state <= ST_LAUNCH;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_challenge = w_lfsr_state;
   assign o_pulse     = r_pulse;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_response  = r_response;

endmodule

// File: tb/tb_puf_response_collector.sv
// -----------------------------------------------------------------------------
// tb_puf_response_collector
// Self-checking bench for puf_response_collector with a behavioural PUF model
// and a scoreboard of expected response words.
// -----------------------------------------------------------------------------
module tb_puf_response_collector;
   import puf_pkg::*;

   localparam int RUN_CYCLES = 8 * DEF_VOTES * (DEF_SETTLE_CYCLES + 2);

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] seed;
   logic       resp_in;
   logic [7:0] challenge;
   logic       pulse;
   logic       busy;
   logic       done;
   logic [7:0] response;

   int n_cmp = 0;
   int n_bad = 0;

   // PUF model: 0 = constant 1, 1 = challenge[0], 2 = 1 on first noisy_ones trials of a group
   int mode       = 0;
   int noisy_ones = 0;
   int pulse_cnt  = 0;
   int pulse_base = 0;
   int trial_no   = 1;
   logic [7:0] chal_log[$];
   logic [7:0] exp_q[$];

   puf_response_collector dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_seed      (seed),
      .i_resp_in   (resp_in),
      .o_challenge (challenge),
      .o_pulse     (pulse),
      .o_busy      (busy),
      .o_done      (done),
      .o_response  (response)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (pulse === 1'b1) begin
         pulse_cnt++;
         trial_no = ((pulse_cnt - pulse_base - 1) % DEF_VOTES) + 1;
         chal_log.push_back(challenge);
      end
      case (mode)
         0:       resp_in = 1'b1;
         1:       resp_in = challenge[0];
         2:       resp_in = (trial_no <= noisy_ones);
         default: resp_in = 1'b0;
      endcase
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic run_and_check(input string name, input logic [7:0] s, input int m,
                                input int n, input logic [7:0] exp_resp,
                                input bit check_chal, input int glitch_at);
      logic [7:0] exp_chal [8];
      logic [7:0] exp_val;
      int lat;
      int chal_base;
      bit got;
      exp_chal = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
      @(negedge clk);
      mode       = m;
      noisy_ones = n;
      pulse_base = pulse_cnt;
      chal_base  = chal_log.size();
      exp_q.push_back(exp_resp);
      seed  = s;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < RUN_CYCLES + 100) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            n_cmp++;
            if (pulse !== 1'b1) begin
               n_bad++;
               $display("FAIL %s first_pulse: got %b, required 1", name, pulse);
            end
         end
         if (glitch_at != 0 && lat == glitch_at) start = 1'b1;
         if (glitch_at != 0 && lat == glitch_at + 1) start = 1'b0;
         if (done === 1'b1) got = 1'b1;
      end
      n_cmp++;
      if (!got) begin
         n_bad++;
         $display("FAIL %s done_timeout: got no done in %0d cycles, required done", name, lat);
         void'(exp_q.pop_front());
         return;
      end
      #1;
      n_cmp++;
      if (lat !== RUN_CYCLES + 1) begin
         n_bad++;
         $display("FAIL %s latency: got %0d, required %0d", name, lat, RUN_CYCLES + 1);
      end
      exp_val = exp_q.pop_front();
      n_cmp++;
      if (response !== exp_val) begin
         n_bad++;
         $display("FAIL %s response: got %h, required %h", name, response, exp_val);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s busy_in_done: got %b, required 0", name, busy);
      end
      n_cmp++;
      if (pulse_cnt - pulse_base !== 8 * DEF_VOTES) begin
         n_bad++;
         $display("FAIL %s pulse_count: got %0d, required %0d", name, pulse_cnt - pulse_base, 8 * DEF_VOTES);
      end
      if (check_chal) begin
         for (int i = 0; i < 8 * DEF_VOTES; i++) begin
            n_cmp++;
            if (chal_log[chal_base + i] !== exp_chal[i / DEF_VOTES]) begin
               n_bad++;
               $display("FAIL %s challenge[%0d]: got %h, required %h", name, i,
                        chal_log[chal_base + i], exp_chal[i / DEF_VOTES]);
            end
         end
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || response !== exp_val) begin
         n_bad++;
         $display("FAIL %s after_done: got done=%b resp=%h, required done=0 resp=%h",
                  name, done, response, exp_val);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      seed  = 8'h55;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (challenge !== 8'h00 || pulse !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || response !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_outputs: got chal=%h pulse=%b busy=%b done=%b resp=%h, required all 0",
                  challenge, pulse, busy, done, response);
      end
      n_cmp++;
      if (dut.r_state !== ST_IDLE) begin
         n_bad++;
         $display("FAIL reset_state: got %0d, required IDLE", dut.r_state);
      end
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || pulse !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: got busy=%b pulse=%b, required 0 0", busy, pulse);
      end
   endtask

   task automatic test_const_one();
      run_and_check("const_one", 8'h01, 0, 0, 8'hFF, 1'b0, 0);
   endtask

   task automatic test_challenge_model();
      run_and_check("chal_bit0", 8'h01, 1, 0, 8'h8E, 1'b1, 0);
   endtask

   task automatic test_noisy();
      run_and_check("noisy_2of5", 8'h5A, 2, 2, 8'h00, 1'b0, 0);
      run_and_check("noisy_3of5", 8'h5A, 2, 3, 8'hFF, 1'b0, 0);
   endtask

   task automatic test_seed_zero();
      run_and_check("seed_zero", 8'h00, 1, 0, 8'h8E, 1'b1, 0);
   endtask

   task automatic test_start_while_busy();
      run_and_check("start_busy", 8'h01, 1, 0, 8'h8E, 1'b1, 50);
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      mode  = 0;
      seed  = 8'h01;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || pulse !== 1'b0 || response !== 8'h00 ||
          done !== 1'b0 || challenge !== 8'h00) begin
         n_bad++;
         $display("FAIL midrun_reset: got busy=%b pulse=%b resp=%h done=%b chal=%h, required all 0",
                  busy, pulse, response, done, challenge);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_cmp++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_quiet[%0d]: got done=%b busy=%b, required 0 0", i, done, busy);
         end
      end
      run_and_check("restart", 8'h01, 1, 0, 8'h8E, 1'b1, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      seed  = 8'h00;
      test_reset();
      test_const_one();
      test_challenge_model();
      test_noisy();
      test_seed_zero();
      test_start_while_busy();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
